alu8_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs 8-bit operations on the team's combinational 4-bit ALU by sequencing two nibble passes (low, then high), chaining carry/borrow and patching shift/rotate boundary bits between passes. Sits between a requester using a valid/ready handshake and one shared 4-bit ALU instance. The ALU itself is external: this block drives its operand/control inputs and samples its result and carry outputs.

---
 rtl/alu8_nibble_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu8_nibble_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_nibble_sequencer.sv
// Sequences 8-bit ADD/SUB/logic/shift/rotate operations as two passes (low nibble,
// then high nibble) through an external combinational 4-bit ALU.
module alu8_nibble_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic       flag,
    output logic       zero,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_control,
    input  logic [3:0] alu_out,
    input  logic       alu_cout
);

    // state | meaning
    // IDLE  | waiting for a request, start_ready high
    // LO    | low-nibble pass, capture result[3:0] and carry/borrow
    // HI    | high-nibble pass with chained carry, capture result[7:4]
    // DONE  | result held with res_valid until res_ready
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       chain_q, chain_d;
    logic [7:0] result_q, result_d;
    logic       flag_q, flag_d;
    logic       zero_q, zero_d;
    logic       is_arith;
    logic [3:0] nib;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        chain_d     = chain_q;
        result_d    = result_q;
        flag_d      = flag_q;
        zero_d      = zero_q;
        alu_a       = 4'h0;
        alu_b       = 4'h0;
        alu_cin     = 1'b0;
        alu_control = 3'b000;
        nib         = alu_out;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    state_d = LO;
                end
            end
            LO: begin
                alu_a       = a_q[3:0];
                alu_b       = b_q[3:0];
                alu_control = op_q;
                alu_cin     = is_arith & cin_q;
                // The ALU only shifts within a nibble; fix up the bits that cross nibbles.
                case (op_q)
                    OP_SHL:  nib[0] = 1'b0;
                    OP_ROL:  nib[0] = a_q[7];
                    OP_SHR:  nib[3] = a_q[4];
                    OP_ROR:  nib[3] = a_q[4];
                    default: nib = alu_out;
                endcase
                result_d = {result_q[7:4], nib};
                chain_d  = alu_cout;
                state_d  = HI;
            end
            HI: begin
                alu_a       = a_q[7:4];
                alu_b       = b_q[7:4];
                alu_control = op_q;
                alu_cin     = is_arith & chain_q;
                case (op_q)
                    OP_SHL:  nib[0] = a_q[3];
                    OP_ROL:  nib[0] = a_q[3];
                    OP_SHR:  nib[3] = 1'b0;
                    OP_ROR:  nib[3] = a_q[0];
                    default: nib = alu_out;
                endcase
                case (op_q)
                    OP_ADD, OP_SUB: flag_d = alu_cout;
                    OP_SHL:         flag_d = a_q[7];
                    OP_SHR:         flag_d = a_q[0];
                    default:        flag_d = 1'b0;
                endcase
                result_d = {nib, result_q[3:0]};
                zero_d   = ({nib, result_q[3:0]} == 8'h00);
                state_d  = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cin_q    <= 1'b0;
            chain_q  <= 1'b0;
            result_q <= 8'h00;
            flag_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            chain_q  <= chain_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            zero_q   <= zero_d;
        end
    end

    assign start_ready = (state_q == IDLE) && rst_n;
    assign res_valid   = (state_q == DONE);
    assign result      = result_q;
    assign flag        = flag_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_alu8_nibble_sequencer.sv
// Bench for alu8_nibble_sequencer: behavioural 4-bit ALU, whole-byte reference model
// checked every cycle, plus directed operations with literal expectations.
module tb_alu8_nibble_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] result;
    logic       flag;
    logic       zero;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_control;
    logic [3:0] alu_out;
    logic       alu_cout;

    int errors = 0;
    int checks = 0;

    alu8_nibble_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .cin(cin), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .flag(flag), .zero(zero), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_control(alu_control), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // External 4-bit ALU
    always_comb begin
        logic [4:0] t;
        t        = 5'd0;
        alu_out  = 4'h0;
        alu_cout = 1'b0;
        case (alu_control)
            3'd0: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin}; alu_out = t[3:0]; alu_cout = t[4]; end
            3'd1: begin t = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_cin}; alu_out = t[3:0]; alu_cout = t[4]; end
            3'd2: alu_out = alu_a | alu_b;
            3'd3: alu_out = alu_a & alu_b;
            3'd4: begin alu_out = {alu_a[2:0], 1'b0}; alu_cout = alu_a[3]; end
            3'd5: begin alu_out = {1'b0, alu_a[3:1]}; alu_cout = alu_a[0]; end
            3'd6: alu_out = {alu_a[2:0], alu_a[3]};
            default: alu_out = {alu_a[0], alu_a[3:1]};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age = cycles since acceptance (-1 idle, 1 low pass, 2 high pass, 3 done)
    int         age = -1;
    bit         model_on = 0;
    logic [2:0] m_op;
    logic [7:0] m_a, m_b, m_res;
    logic       m_cin, m_flag, m_locarry;

    function automatic void model_accept();
        logic [8:0] s;
        int lo;
        m_op = op; m_a = a; m_b = b; m_cin = cin;
        s = 9'd0;
        m_flag = 1'b0;
        m_locarry = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                m_res = s[7:0]; m_flag = s[8];
                lo = int'(a[3:0]) + int'(b[3:0]) + int'(cin);
                m_locarry = (lo > 15);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                m_res = s[7:0]; m_flag = s[8];
                lo = int'(a[3:0]) - int'(b[3:0]) - int'(cin);
                m_locarry = (lo < 0);
            end
            3'd2: m_res = a | b;
            3'd3: m_res = a & b;
            3'd4: begin m_res = a << 1; m_flag = a[7]; end
            3'd5: begin m_res = a >> 1; m_flag = a[0]; end
            3'd6: m_res = {a[6:0], a[7]};
            default: m_res = {a[0], a[7:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        model_on = 1;
        if (!rst_n) age = -1;
        else if (age < 0) begin
            if (start_valid) begin
                model_accept();
                age = 1;
            end
        end else if (age < 3) age = age + 1;
        else if (res_ready) age = -1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("start_ready", start_ready, (age < 0) && rst_n);
            chk("res_valid", res_valid, age >= 3);
            if (age >= 3) begin
                chk("result", result, m_res);
                chk("flag", flag, m_flag);
                chk("zero", zero, m_res == 8'h00);
            end
            if (age == 1) begin
                chk("lo_alu_a", alu_a, m_a[3:0]);
                chk("lo_alu_b", alu_b, m_b[3:0]);
                chk("lo_alu_ctl", alu_control, m_op);
                chk("lo_alu_cin", alu_cin, (m_op <= 3'd1) ? m_cin : 1'b0);
            end else if (age == 2) begin
                chk("hi_alu_a", alu_a, m_a[7:4]);
                chk("hi_alu_b", alu_b, m_b[7:4]);
                chk("hi_alu_ctl", alu_control, m_op);
                chk("hi_alu_cin", alu_cin, (m_op <= 3'd1) ? m_locarry : 1'b0);
            end else begin
                chk("idle_alu", {alu_a, alu_b, alu_cin, alu_control}, 12'h000);
            end
        end
    end

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic early_ready, input logic [7:0] exp_res,
                          input logic exp_flag, input logic exp_zero, output logic hi_cin);
        op = o; a = x; b = y; cin = c; start_valid = 1'b1;
        res_ready = early_ready;
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("lit_busy_lo", res_valid, 1'b0);
        @(posedge clk); #1;
        hi_cin = alu_cin;
        chk("lit_busy_hi", res_valid, 1'b0);
        @(posedge clk); #1;
        chk("lit_valid", res_valid, 1'b1);
        chk("lit_result", result, exp_res);
        chk("lit_flag", flag, exp_flag);
        chk("lit_zero", zero, exp_zero);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("lit_back_idle", start_ready, 1'b1);
    endtask

    initial begin
        logic hc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_ready", start_ready, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flag", flag, 1'b0);
        chk("rst_zero", zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 8'h9C, 8'h75, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, hc);
        chk("add_hi_cin", hc, 1'b1);
        run_op(3'd1, 8'h30, 8'h31, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, hc);
        chk("sub_hi_borrow", hc, 1'b1);
        run_op(3'd4, 8'h81, 8'h5A, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, hc);
        run_op(3'd5, 8'h81, 8'h5A, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, hc);
        run_op(3'd6, 8'h81, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, hc);
        run_op(3'd7, 8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, hc);
        run_op(3'd3, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, hc);
        run_op(3'd2, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, hc);
        run_op(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, hc);
        run_op(3'd7, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h2D, 1'b0, 1'b0, hc);

        // Backpressure with a second request held pending
        op = 3'd0; a = 8'h12; b = 8'h34; cin = 1'b1; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        op = 3'd2; a = 8'hFF; b = 8'h34; cin = 1'b0; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", result, 8'h47);
            chk("bp_flag", flag, 1'b0);
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_ready", start_ready, 1'b0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_idle_ready", start_ready, 1'b1);
        chk("bp_idle_valid", res_valid, 1'b0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("bp_accepted", start_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp2_valid", res_valid, 1'b1);
        chk("bp2_result", result, 8'hFF);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset during the high-nibble pass
        op = 3'd0; a = 8'h55; b = 8'h66; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_result", result, 8'h00);
        chk("mid_rst_ready", start_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", res_valid, 1'b0);
        run_op(3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, hc);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
